// File: rtl/fp_sched_pkg.sv
// Shared constants, FSM state encoding and small helpers for the ping-pong frame scheduler.
package fp_sched_pkg;

  localparam int N_SAMP_DEF  = 64;
  localparam int SAMP_IDX_W  = $clog2(N_SAMP_DEF);
  localparam int FRAME_NUM_W = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_DONE = 2'd2
  } sched_state_e;

  function automatic logic [FRAME_NUM_W-1:0] frame_num_inc(input logic [FRAME_NUM_W-1:0] n);
    return n + 7'd1;
  endfunction

  function automatic logic [1:0] bank_onehot(input logic bank);
    return bank ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/frame_bank.sv
// Two frame-wide storage registers with per-bank write enables and a
// sample-granular read mux addressed by bank and sample index.
module frame_bank
  import fp_sched_pkg::*;
#(
  parameter int I_BW   = 14,
  parameter int N_SAMP = 64
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [1:0]             i_we,
  input  logic [I_BW*N_SAMP-1:0] i_data,
  input  logic                   i_rd_bank,
  input  logic [SAMP_IDX_W-1:0]  i_rd_idx,
  output logic [I_BW-1:0]        o_sample
);

  logic [1:0][I_BW*N_SAMP-1:0] r_bank;

  // Frame storage, written whole on accept.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_bank <= '0;
    end else begin
      if (i_we[0]) r_bank[0] <= i_data;
      if (i_we[1]) r_bank[1] <= i_data;
    end
  end

  // Sample select from the bank currently being read.
  always_comb begin
    o_sample = r_bank[i_rd_bank][32'(i_rd_idx) * I_BW +: I_BW];
  end

endmodule

// File: rtl/frame_pingpong_scheduler.sv
// Ping-pong frame scheduler: accepts whole frames into two banks and paces
// them out one tagged sample at a time, with ordering check and end-of-stream.
module frame_pingpong_scheduler
  import fp_sched_pkg::*;
#(
  parameter int I_BW     = 14,
  parameter int N_SAMP   = 64,
  parameter int N_FRAMES = 89,
  parameter int PERIOD   = 9
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          di_en,
  output logic                          di_rdy,
  input  logic [I_BW*N_SAMP-1:0]        data_i,
  input  logic [FRAME_NUM_W-1:0]        in_group_num,
  output logic                          do_en,
  output logic signed [I_BW-1:0]        data_o,
  output logic [SAMP_IDX_W-1:0]         out_group_idx,
  output logic [FRAME_NUM_W-1:0]        out_group_num,
  output logic                          out_last,
  output logic                          err_order,
  output logic                          done
);

  localparam int PACE_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  sched_state_e                 r_state;
  logic [1:0]                   r_full;
  logic [1:0][FRAME_NUM_W-1:0]  r_num;
  logic                         r_wr_bank;
  logic                         r_rd_bank;
  logic [FRAME_NUM_W-1:0]       r_exp_num;
  logic [FRAME_NUM_W-1:0]       r_frames_out;
  logic [SAMP_IDX_W-1:0]        r_idx;
  logic [PACE_W-1:0]            r_pace;

  logic                         w_accept;
  logic                         w_emit;
  logic                         w_last;
  logic [1:0]                   w_we;
  logic [1:0]                   w_clr;
  logic [1:0]                   w_full_nxt;
  logic [I_BW-1:0]              w_sample;

  frame_bank #(
    .I_BW   (I_BW),
    .N_SAMP (N_SAMP)
  ) u_bank (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_we      (w_we),
    .i_data    (data_i),
    .i_rd_bank (r_rd_bank),
    .i_rd_idx  (r_idx),
    .o_sample  (w_sample)
  );

  // Handshake, emit decision and bank flag updates; ready depends on registered state only.
  always_comb begin
    di_rdy   = ~r_full[r_wr_bank] & ~done;
    w_accept = di_en & di_rdy;
    w_last   = (r_idx == SAMP_IDX_W'(N_SAMP - 1));
    case (r_state)
      ST_IDLE: w_emit = r_full[r_rd_bank];
      ST_EMIT: w_emit = (r_pace == '0);
      ST_DONE: w_emit = 1'b0;
      default: w_emit = 1'b0;
    endcase
    if (w_accept) begin
      w_we = bank_onehot(r_wr_bank);
    end else begin
      w_we = 2'b00;
    end
    if (w_emit && w_last) begin
      w_clr = bank_onehot(r_rd_bank);
    end else begin
      w_clr = 2'b00;
    end
    // Accept and free always target different banks, so both apply together.
    w_full_nxt = (r_full & ~w_clr) | w_we;
  end

  // Read FSM, pointers, pace counter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_full        <= 2'b00;
      r_num         <= '0;
      r_wr_bank     <= 1'b0;
      r_rd_bank     <= 1'b0;
      r_exp_num     <= '0;
      r_frames_out  <= '0;
      r_idx         <= '0;
      r_pace        <= '0;
      do_en         <= 1'b0;
      data_o        <= '0;
      out_group_idx <= '0;
      out_group_num <= '0;
      out_last      <= 1'b0;
      err_order     <= 1'b0;
      done          <= 1'b0;
    end else begin
      r_full    <= w_full_nxt;
      do_en     <= w_emit;
      err_order <= w_accept && (in_group_num != r_exp_num);
      if (w_accept) begin
        r_num[r_wr_bank] <= in_group_num;
        r_wr_bank        <= ~r_wr_bank;
        r_exp_num        <= frame_num_inc(r_exp_num);
      end
      if (w_emit) begin
        data_o        <= w_sample;
        out_group_idx <= r_idx;
        out_group_num <= r_num[r_rd_bank];
        out_last      <= w_last;
        r_pace        <= PACE_W'(PERIOD - 1);
        if (w_last) begin
          r_idx        <= '0;
          r_rd_bank    <= ~r_rd_bank;
          r_frames_out <= frame_num_inc(r_frames_out);
          if (r_frames_out == FRAME_NUM_W'(N_FRAMES - 1)) begin
            done    <= 1'b1;
            r_state <= ST_DONE;
          end else if (r_full[~r_rd_bank]) begin
            r_state <= ST_EMIT;
          end else begin
            r_state <= ST_IDLE;
          end
        end else begin
          r_idx   <= r_idx + 6'd1;
          r_state <= ST_EMIT;
        end
      end else if (r_state == ST_EMIT) begin
        r_pace <= r_pace - PACE_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_frame_pingpong_scheduler.sv
// Randomized self-checking bench for frame_pingpong_scheduler with a
// frame-queue reference model predicting every output each cycle.
module tb_frame_pingpong_scheduler;

  localparam int I_BW     = 14;
  localparam int N_SAMP   = 64;
  localparam int N_FRAMES = 89;
  localparam int PERIOD   = 9;
  localparam int FW       = I_BW * N_SAMP;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                   di_en = 1'b0;
  logic                   di_rdy;
  logic [FW-1:0]          data_i = '0;
  logic [6:0]             in_group_num = '0;
  logic                   do_en;
  logic signed [I_BW-1:0] data_o;
  logic [5:0]             out_group_idx;
  logic [6:0]             out_group_num;
  logic                   out_last, err_order, done;

  logic                   di_en1 = 1'b0;
  logic                   di_rdy1;
  logic [FW-1:0]          data_i1 = '0;
  logic [6:0]             in_group_num1 = '0;
  logic                   do_en1;
  logic signed [I_BW-1:0] data_o1;
  logic [5:0]             out_group_idx1;
  logic [6:0]             out_group_num1;
  logic                   out_last1, err_order1, done1;

  frame_pingpong_scheduler #(.I_BW(I_BW), .N_SAMP(N_SAMP), .N_FRAMES(N_FRAMES), .PERIOD(PERIOD)) dut (
    .clk(clk), .rst(rst), .di_en(di_en), .di_rdy(di_rdy), .data_i(data_i),
    .in_group_num(in_group_num), .do_en(do_en), .data_o(data_o),
    .out_group_idx(out_group_idx), .out_group_num(out_group_num),
    .out_last(out_last), .err_order(err_order), .done(done));

  frame_pingpong_scheduler #(.I_BW(I_BW), .N_SAMP(N_SAMP), .N_FRAMES(N_FRAMES), .PERIOD(1)) dut1 (
    .clk(clk), .rst(rst), .di_en(di_en1), .di_rdy(di_rdy1), .data_i(data_i1),
    .in_group_num(in_group_num1), .do_en(do_en1), .data_o(data_o1),
    .out_group_idx(out_group_idx1), .out_group_num(out_group_num1),
    .out_last(out_last1), .err_order(err_order1), .done(done1));

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: a queue of held frames, emitted in order at PERIOD pitch.
  logic [FW-1:0] q_data[$];
  logic [6:0]    q_num[$];
  int            m_cyc, m_tnext, m_samp, m_exp, m_fout;
  bit            m_done, m_doen, m_err, m_last, m_acc;
  logic [13:0]   m_data;
  logic [5:0]    m_oidx;
  logic [6:0]    m_onum;

  // Stimulus source.
  logic [FW-1:0] s_data[$];
  logic [6:0]    s_num[$];
  int            en_pct = 100;

  function automatic void model_reset();
    q_data.delete(); q_num.delete();
    m_tnext = 0; m_samp = 0; m_exp = 0; m_fout = 0;
    m_done = 1'b0; m_doen = 1'b0; m_err = 1'b0; m_last = 1'b0; m_acc = 1'b0;
    m_data = '0; m_oidx = '0; m_onum = '0;
  endfunction

  function automatic bit model_rdy();
    return (q_data.size() < 2) && !m_done;
  endfunction

  function automatic void model_edge(input bit en, input logic [FW-1:0] d, input logic [6:0] num);
    bit emit;
    logic [FW-1:0] f;
    m_cyc++;
    m_acc = en && model_rdy();
    emit  = (q_data.size() > 0) && !m_done && (m_cyc >= m_tnext);
    m_doen = emit;
    m_err  = m_acc && (int'(num) != (m_exp % 128));
    if (emit) begin
      f = q_data[0];
      m_data = f[m_samp*I_BW +: I_BW];
      m_oidx = 6'(m_samp);
      m_onum = q_num[0];
      m_last = (m_samp == N_SAMP - 1);
      m_tnext = m_cyc + PERIOD;
      if (m_last) begin
        void'(q_data.pop_front());
        void'(q_num.pop_front());
        m_fout++;
        m_samp = 0;
        if (m_fout == N_FRAMES) m_done = 1'b1;
      end else begin
        m_samp++;
      end
    end
    if (m_acc) begin
      q_data.push_back(d);
      q_num.push_back(num);
      m_exp++;
      if (q_data.size() == 1) begin
        m_tnext = m_cyc + 1;
        m_samp  = 0;
      end
    end
  endfunction

  function automatic logic [31:0] exp_vec();
    return {model_rdy(), m_doen, m_data, m_oidx, m_onum, m_last, m_err, m_done};
  endfunction

  function automatic logic [31:0] dut_vec();
    return {di_rdy, do_en, data_o, out_group_idx, out_group_num, out_last, err_order, done};
  endfunction

  function automatic logic [FW-1:0] ramp_frame();
    logic [FW-1:0] f;
    for (int k = 0; k < N_SAMP; k++) f[k*I_BW +: I_BW] = I_BW'(k - 32);
    return f;
  endfunction

  function automatic logic [FW-1:0] rand_frame();
    logic [FW-1:0] f;
    for (int k = 0; k < N_SAMP; k++) f[k*I_BW +: I_BW] = I_BW'($urandom);
    return f;
  endfunction

  task automatic clk_step();
    if (s_data.size() > 0 && ($urandom_range(99) < en_pct)) begin
      di_en = 1'b1; data_i = s_data[0]; in_group_num = s_num[0];
    end else begin
      di_en = 1'b0;
    end
    @(posedge clk);
    model_edge(di_en, data_i, in_group_num);
    if (m_acc) begin
      void'(s_data.pop_front());
      void'(s_num.pop_front());
    end
    #1;
  endtask

  task automatic do_reset();
    di_en = 1'b0; di_en1 = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    s_data.delete(); s_num.delete();
    en_pct = 100;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (dut_vec() !== 32'h8000_0000) begin
      n_errors++; $display("FAIL reset_state got=%h want=%h", dut_vec(), 32'h8000_0000);
    end
    n_checks++;
    if ({di_rdy1, do_en1, data_o1, out_group_idx1, out_group_num1, out_last1, err_order1, done1} !== 32'h8000_0000) begin
      n_errors++; $display("FAIL reset_state_p1 got=%h want=%h",
        {di_rdy1, do_en1, data_o1, out_group_idx1, out_group_num1, out_last1, err_order1, done1}, 32'h8000_0000);
    end
  endtask

  task automatic test_single_frame();
    int pulses = 0, lasts = 0;
    do_reset();
    s_data.push_back(ramp_frame()); s_num.push_back(7'd0);
    repeat (N_SAMP * PERIOD + 20) begin
      clk_step();
      n_checks++;
      if (dut_vec() !== exp_vec()) begin
        n_errors++; $display("FAIL single cyc=%0d got=%h want=%h", m_cyc, dut_vec(), exp_vec());
      end
      if (do_en) begin
        n_checks++;
        if (data_o !== 14'(pulses - 32)) begin
          n_errors++; $display("FAIL single_ramp k=%0d got=%0d want=%0d", pulses, data_o, pulses - 32);
        end
        pulses++;
        if (out_last) lasts++;
      end
    end
    n_checks++;
    if (pulses != N_SAMP || lasts != 1) begin
      n_errors++; $display("FAIL single_count pulses=%0d lasts=%0d want 64/1", pulses, lasts);
    end
  endtask

  task automatic test_back_pressure();
    int pulses = 0, bad_gaps = 0, t = 0, t_prev = -1;
    do_reset();
    for (int i = 0; i < 3; i++) begin s_data.push_back(rand_frame()); s_num.push_back(7'(i)); end
    repeat (3 * N_SAMP * PERIOD + 20) begin
      clk_step();
      t++;
      n_checks++;
      if (dut_vec() !== exp_vec()) begin
        n_errors++; $display("FAIL backpressure cyc=%0d got=%h want=%h", m_cyc, dut_vec(), exp_vec());
      end
      if (do_en) begin
        if (t_prev >= 0 && (t - t_prev) != PERIOD) bad_gaps++;
        t_prev = t;
        pulses++;
      end
    end
    n_checks++;
    if (pulses != 3 * N_SAMP || bad_gaps != 0) begin
      n_errors++; $display("FAIL backpressure_pitch pulses=%0d bad_gaps=%0d want 192/0", pulses, bad_gaps);
    end
  endtask

  task automatic test_order_error();
    int errs = 0, tagged2 = 0;
    do_reset();
    s_data.push_back(rand_frame()); s_num.push_back(7'd0);
    s_data.push_back(rand_frame()); s_num.push_back(7'd2);
    repeat (2 * N_SAMP * PERIOD + 20) begin
      clk_step();
      n_checks++;
      if (dut_vec() !== exp_vec()) begin
        n_errors++; $display("FAIL order cyc=%0d got=%h want=%h", m_cyc, dut_vec(), exp_vec());
      end
      if (err_order) errs++;
      if (do_en && out_group_num == 7'd2) tagged2++;
    end
    n_checks++;
    if (errs != 1 || tagged2 != N_SAMP) begin
      n_errors++; $display("FAIL order_count errs=%0d tagged2=%0d want 1/64", errs, tagged2);
    end
  endtask

  task automatic test_reset_mid_frame();
    bit hit = 1'b0;
    do_reset();
    for (int i = 0; i < 6; i++) begin s_data.push_back(rand_frame()); s_num.push_back(7'(i)); end
    for (int c = 0; c < 6 * N_SAMP * PERIOD + 50 && !hit; c++) begin
      clk_step();
      n_checks++;
      if (dut_vec() !== exp_vec()) begin
        n_errors++; $display("FAIL midreset_run cyc=%0d got=%h want=%h", m_cyc, dut_vec(), exp_vec());
      end
      if (m_doen && m_onum == 7'd5 && m_oidx == 6'd30) hit = 1'b1;
    end
    n_checks++;
    if (!hit) begin
      n_errors++; $display("FAIL midreset_timeout got=no idx30 of frame5 want=reached");
    end
    di_en = 1'b0;
    rst = 1'b1;
    #1;
    n_checks++;
    if (dut_vec() !== 32'h8000_0000) begin
      n_errors++; $display("FAIL midreset_async got=%h want=%h", dut_vec(), 32'h8000_0000);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    s_data.delete(); s_num.delete();
    s_data.push_back(ramp_frame()); s_num.push_back(7'd0);
    repeat (40) begin
      clk_step();
      n_checks++;
      if (dut_vec() !== exp_vec()) begin
        n_errors++; $display("FAIL midreset_restart cyc=%0d got=%h want=%h", m_cyc, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_full_utterance();
    int pulses = 0, late = 0, tail = 0, c = 0;
    bit done_seen = 1'b0;
    do_reset();
    en_pct = 70;
    for (int i = 0; i < N_FRAMES + 3; i++) begin s_data.push_back(rand_frame()); s_num.push_back(7'(i)); end
    while (c < 60000 && tail < 40) begin
      clk_step();
      c++;
      n_checks++;
      if (dut_vec() !== exp_vec()) begin
        n_errors++; $display("FAIL utterance cyc=%0d got=%h want=%h", m_cyc, dut_vec(), exp_vec());
      end
      if (do_en && done_seen) late++;
      if (do_en) pulses++;
      if (done && !done_seen) begin
        done_seen = 1'b1;
        n_checks++;
        if (!(do_en && out_last)) begin
          n_errors++; $display("FAIL done_edge do_en=%0b out_last=%0b want 1/1", do_en, out_last);
        end
      end
      if (m_done) tail++;
    end
    n_checks++;
    if (pulses != N_FRAMES * N_SAMP || !done_seen || late != 0) begin
      n_errors++; $display("FAIL utterance_total pulses=%0d done=%0b late=%0d want 5696/1/0", pulses, done_seen, late);
    end
  endtask

  task automatic test_period1();
    logic [FW-1:0] fa, fb, f;
    int pulses = 0, run = 0, best = 0;
    do_reset();
    fa = rand_frame(); fb = rand_frame();
    di_en1 = 1'b1; data_i1 = fa; in_group_num1 = 7'd0;
    n_checks++;
    if (di_rdy1 !== 1'b1) begin n_errors++; $display("FAIL p1_rdy0 got=%0b want=1", di_rdy1); end
    @(posedge clk); #1;
    data_i1 = fb; in_group_num1 = 7'd1;
    n_checks++;
    if (di_rdy1 !== 1'b1) begin n_errors++; $display("FAIL p1_rdy1 got=%0b want=1", di_rdy1); end
    @(posedge clk); #1;
    di_en1 = 1'b0;
    repeat (200) begin
      if (do_en1) begin
        f = (pulses < N_SAMP) ? fa : fb;
        n_checks++;
        if (data_o1 !== f[(pulses % N_SAMP)*I_BW +: I_BW]) begin
          n_errors++; $display("FAIL p1_data k=%0d got=%h want=%h", pulses, data_o1, f[(pulses % N_SAMP)*I_BW +: I_BW]);
        end
        pulses++; run++;
        if (run > best) best = run;
      end else begin
        run = 0;
      end
      @(posedge clk); #1;
    end
    n_checks++;
    if (best != 2 * N_SAMP || pulses != 2 * N_SAMP) begin
      n_errors++; $display("FAIL p1_continuous run=%0d pulses=%0d want 128/128", best, pulses);
    end
  endtask

  initial begin
    m_cyc = 0;
    model_reset();
    test_reset();
    test_single_frame();
    test_back_pressure();
    test_order_error();
    test_reset_mid_frame();
    test_period1();
    test_full_utterance();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout want=completion");
    $fatal(1, "watchdog expired");
  end

endmodule
